// File: rtl/fpaddsub_ctrl_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fpaddsub_ctrl_pkg: shared types for the FP32 add/sub issue arbiter. Rev 1.0
// -----------------------------------------------------------------------------
package fpaddsub_ctrl_pkg;

  localparam int FP_W        = 32;
  localparam int LAT_DEFAULT = 4;

  typedef logic owner_t;

  localparam owner_t OWNER0 = 1'b0;
  localparam owner_t OWNER1 = 1'b1;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  function automatic owner_t other_owner(owner_t o);
    return ~o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpaddsub_rsp_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fpaddsub_rsp_fifo: first-word fall-through result FIFO, DEPTH entries. Rev 1.0
// -----------------------------------------------------------------------------
module fpaddsub_rsp_fifo
  import fpaddsub_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [FP_W-1:0] push_data,
  input  logic            pop,
  output logic            empty,
  output logic [FP_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [FP_W-1:0] mem_q [DEPTH];
  logic [FP_W-1:0] mem_d [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count;
  logic            full;
  logic            wr_en;
  logic            rd_en;

  // One extra pointer bit separates the full and empty cases.
  always_comb begin
    count = wr_ptr_q - rd_ptr_q;
    empty = (count == '0);
    full  = (count == (AW+1)'(DEPTH));
    wr_en = push && !full;
    rd_en = pop && !empty;
    head  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/fpaddsub_issue_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fpaddsub_issue_arbiter: round-robin issue of two requesters into one
// fixed-latency FP32 add/sub pipe, with credit-protected response FIFOs. Rev 1.0
// -----------------------------------------------------------------------------
module fpaddsub_issue_arbiter
  import fpaddsub_ctrl_pkg::*;
#(
  parameter int LAT   = LAT_DEFAULT,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_op,
  output logic        fpu_valid,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic        fpu_op,
  input  logic [31:0] fpu_result,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        busy
);

  localparam int            CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);

  logic            elig0, elig1;
  logic            grant0, grant1;
  owner_t          rr_q, rr_d;
  logic            fpu_valid_q, fpu_valid_d;
  logic [FP_W-1:0] fpu_a_q, fpu_a_d;
  logic [FP_W-1:0] fpu_b_q, fpu_b_d;
  op_t             fpu_op_q, fpu_op_d;
  owner_t          fpu_owner_q, fpu_owner_d;
  tag_t            tag_q [LAT];
  tag_t            tag_d [LAT];
  tag_t            tail;
  logic [CW-1:0]   credit0_q, credit0_d;
  logic [CW-1:0]   credit1_q, credit1_d;
  logic            push0, push1;
  logic            pop0, pop1;
  logic            empty0, empty1;
  logic            tags_busy;

  function automatic logic [CW-1:0] credit_next(logic [CW-1:0] cur, logic take, logic give);
    credit_next = cur;
    if (take && !give && cur != '0) begin
      credit_next = cur - CW'(1);
    end else if (give && !take && cur != CREDIT_MAX) begin
      credit_next = cur + CW'(1);
    end
  endfunction

  // Grants are gated by reset so no handshake can be seen while rst is low.
  always_comb begin
    elig0  = req0_valid && (credit0_q != '0);
    elig1  = req1_valid && (credit1_q != '0);
    grant0 = rst && elig0 && (!elig1 || rr_q == OWNER0);
    grant1 = rst && elig1 && !grant0;
    req0_ready = grant0;
    req1_ready = grant1;
  end

  always_comb begin
    rr_d        = rr_q;
    fpu_valid_d = grant0 || grant1;
    fpu_a_d     = fpu_a_q;
    fpu_b_d     = fpu_b_q;
    fpu_op_d    = fpu_op_q;
    fpu_owner_d = fpu_owner_q;
    if (grant0) begin
      rr_d        = other_owner(OWNER0);
      fpu_a_d     = req0_a;
      fpu_b_d     = req0_b;
      fpu_op_d    = op_t'(req0_op);
      fpu_owner_d = OWNER0;
    end else if (grant1) begin
      rr_d        = other_owner(OWNER1);
      fpu_a_d     = req1_a;
      fpu_b_d     = req1_b;
      fpu_op_d    = op_t'(req1_op);
      fpu_owner_d = OWNER1;
    end
  end

  // The tag pipe follows the issue register, so its tail lines up with fpu_result.
  always_comb begin
    tag_d[0] = '{valid: fpu_valid_q, owner: fpu_owner_q};
    for (int i = 1; i < LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    tail      = tag_q[LAT-1];
    tags_busy = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      tags_busy = tags_busy | tag_q[i].valid;
    end
    push0 = tail.valid && (tail.owner == OWNER0);
    push1 = tail.valid && (tail.owner == OWNER1);
    pop0  = rsp0_ready && !empty0;
    pop1  = rsp1_ready && !empty1;
  end

  always_comb begin
    credit0_d = credit_next(credit0_q, grant0, pop0);
    credit1_d = credit_next(credit1_q, grant1, pop1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q        <= OWNER0;
      fpu_valid_q <= 1'b0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      fpu_op_q    <= OP_ADD;
      fpu_owner_q <= OWNER0;
      credit0_q   <= CREDIT_MAX;
      credit1_q   <= CREDIT_MAX;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      rr_q        <= rr_d;
      fpu_valid_q <= fpu_valid_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      fpu_op_q    <= fpu_op_d;
      fpu_owner_q <= fpu_owner_d;
      credit0_q   <= credit0_d;
      credit1_q   <= credit1_d;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  fpaddsub_rsp_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (fpu_result),
    .pop       (pop0),
    .empty     (empty0),
    .head      (rsp0_result)
  );

  fpaddsub_rsp_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (fpu_result),
    .pop       (pop1),
    .empty     (empty1),
    .head      (rsp1_result)
  );

  always_comb begin
    fpu_valid  = fpu_valid_q;
    fpu_a      = fpu_a_q;
    fpu_b      = fpu_b_q;
    fpu_op     = fpu_op_q;
    rsp0_valid = !empty0;
    rsp1_valid = !empty1;
    busy       = tags_busy || fpu_valid_q || !empty0 || !empty1;
  end

endmodule
`default_nettype wire
